// File: rtl/tpu_host_ctrl.sv
// Host-side initiator for the TPU: loads the A/B buffers from a word stream, starts the TPU and streams C back out.
// Optional busy-phase watchdog with sticky timeout_err is enabled by defining TPU_HOST_TIMEOUT_EN.
module tpu_host_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cfg_valid,
   output logic         cfg_ready,
   input  logic [7:0]   cfg_K,
   input  logic [7:0]   cfg_M,
   input  logic [7:0]   cfg_N,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [31:0]  s_data,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [127:0] m_data,
   output logic         m_last,
   output logic         done,
`ifdef TPU_HOST_TIMEOUT_EN
   output logic         timeout_err,
`endif
   output logic         tpu_in_valid,
   output logic [7:0]   tpu_K,
   output logic [7:0]   tpu_M,
   output logic [7:0]   tpu_N,
   input  logic         tpu_busy,
   output logic         A_wr_en,
   output logic [15:0]  A_index,
   output logic [31:0]  A_data_in,
   input  logic [31:0]  A_data_out,
   output logic         B_wr_en,
   output logic [15:0]  B_index,
   output logic [31:0]  B_data_in,
   input  logic [31:0]  B_data_out,
   output logic         C_wr_en,
   output logic [15:0]  C_index,
   output logic [127:0] C_data_in,
   input  logic [127:0] C_data_out
);

   typedef enum logic [3:0] {
      IDLE, LOAD_A, LOAD_B, START, WAIT_HI, WAIT_LO, C_REQ, C_WAIT, C_OUT, FINISH
   } state_t;

   state_t         state_q, state_d;
   logic [7:0]     k_q, k_d, m_q, m_d, n_q, n_d;
   logic [15:0]    na_q, na_d, nbw_q, nbw_d, nc_q, nc_d;
   logic [15:0]    a_idx_q, a_idx_d, b_idx_q, b_idx_d, c_idx_q, c_idx_d;
   logic [127:0]   m_data_q, m_data_d;
   logic           m_valid_q, m_valid_d, done_q, done_d;
   logic [6:0]     mb, nb;
   logic [15:0]    na_calc, nbw_calc, nc_calc;
   logic           tmo_hit, tmo_fire;
   logic           unused_in;

   // Block counts round partial 4-element groups up to a whole word.
   assign mb       = 7'(({1'b0, cfg_M} + 9'd3) >> 2);
   assign nb       = 7'(({1'b0, cfg_N} + 9'd3) >> 2);
   assign na_calc  = {8'd0, cfg_K} * {9'd0, mb};
   assign nbw_calc = {8'd0, cfg_K} * {9'd0, nb};
   assign nc_calc  = {8'd0, cfg_M} * {9'd0, nb};

   assign tpu_K     = k_q;
   assign tpu_M     = m_q;
   assign tpu_N     = n_q;
   assign A_index   = a_idx_q;
   assign B_index   = b_idx_q;
   assign C_index   = c_idx_q;
   assign C_wr_en   = 1'b0;
   assign C_data_in = '0;
   assign m_data    = m_data_q;
   assign m_valid   = m_valid_q;
   assign m_last    = m_valid_q && (c_idx_q == nc_q - 16'd1);
   assign done      = done_q;
   assign unused_in = ^{A_data_out, B_data_out};

`ifdef TPU_HOST_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic        tmo_err_q, tmo_err_d;

   assign tmo_hit     = (tmo_cnt_q == TMO_LAST);
   assign timeout_err = tmo_err_q;

   // Counter restarts on every state change, so each busy phase gets its own budget.
   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      if (state_d != state_q)
         tmo_cnt_d = '0;
      else if (state_q == WAIT_HI || state_q == WAIT_LO)
         tmo_cnt_d = tmo_cnt_q + 16'd1;
      tmo_err_d = tmo_err_q;
      if (cfg_valid && cfg_ready) tmo_err_d = 1'b0;
      if (tmo_fire)               tmo_err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_q <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         tmo_err_q <= tmo_err_d;
      end
   end
`else
   logic unused_tmo;
   assign tmo_hit    = 1'b0;
   assign unused_tmo = tmo_fire ^ (TIMEOUT_CYCLES == 0);
`endif

   always_comb begin
      state_d      = state_q;
      k_d          = k_q;
      m_d          = m_q;
      n_d          = n_q;
      na_d         = na_q;
      nbw_d        = nbw_q;
      nc_d         = nc_q;
      a_idx_d      = a_idx_q;
      b_idx_d      = b_idx_q;
      c_idx_d      = c_idx_q;
      m_data_d     = m_data_q;
      m_valid_d    = m_valid_q;
      done_d       = 1'b0;
      tmo_fire     = 1'b0;
      cfg_ready    = (state_q == IDLE);
      s_ready      = (state_q == LOAD_A) || (state_q == LOAD_B);
      tpu_in_valid = 1'b0;
      A_wr_en      = 1'b0;
      A_data_in    = '0;
      B_wr_en      = 1'b0;
      B_data_in    = '0;
      case (state_q)
         IDLE: begin
            if (cfg_valid) begin
               k_d     = cfg_K;
               m_d     = cfg_M;
               n_d     = cfg_N;
               na_d    = na_calc;
               nbw_d   = nbw_calc;
               nc_d    = nc_calc;
               a_idx_d = '0;
               b_idx_d = '0;
               c_idx_d = '0;
               state_d = (cfg_K == 8'd0 || cfg_M == 8'd0 || cfg_N == 8'd0) ? FINISH : LOAD_A;
            end
         end
         LOAD_A: begin
            if (s_valid) begin
               A_wr_en   = 1'b1;
               A_data_in = s_data;
               if (a_idx_q == na_q - 16'd1) state_d = LOAD_B;
               else                         a_idx_d = a_idx_q + 16'd1;
            end
         end
         LOAD_B: begin
            if (s_valid) begin
               B_wr_en   = 1'b1;
               B_data_in = s_data;
               if (b_idx_q == nbw_q - 16'd1) state_d = START;
               else                          b_idx_d = b_idx_q + 16'd1;
            end
         end
         START: begin
            tpu_in_valid = 1'b1;
            state_d      = WAIT_HI;
         end
         WAIT_HI: begin
            if (tpu_busy) state_d = WAIT_LO;
            else if (tmo_hit) begin
               state_d  = FINISH;
               tmo_fire = 1'b1;
            end
         end
         WAIT_LO: begin
            if (!tpu_busy) begin
               c_idx_d = '0;
               state_d = C_REQ;
            end else if (tmo_hit) begin
               state_d  = FINISH;
               tmo_fire = 1'b1;
            end
         end
         C_REQ:  state_d = C_WAIT;
         // C_data_out reflects C_index one cycle after it was driven in C_REQ.
         C_WAIT: begin
            m_data_d  = C_data_out;
            m_valid_d = 1'b1;
            state_d   = C_OUT;
         end
         C_OUT: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               if (c_idx_q == nc_q - 16'd1) state_d = FINISH;
               else begin
                  c_idx_d = c_idx_q + 16'd1;
                  state_d = C_REQ;
               end
            end
         end
         FINISH: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         k_q       <= '0;
         m_q       <= '0;
         n_q       <= '0;
         na_q      <= '0;
         nbw_q     <= '0;
         nc_q      <= '0;
         a_idx_q   <= '0;
         b_idx_q   <= '0;
         c_idx_q   <= '0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         m_q       <= m_d;
         n_q       <= n_d;
         na_q      <= na_d;
         nbw_q     <= nbw_d;
         nc_q      <= nc_d;
         a_idx_q   <= a_idx_d;
         b_idx_q   <= b_idx_d;
         c_idx_q   <= c_idx_d;
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
         done_q    <= done_d;
      end
   end

endmodule
